// File: rtl/alu_pkg.sv
// Shared constants for the ALU sequencer: opcodes,
// flag bit positions and the sequencer FSM encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_COMP = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_SHL  = 3'b111;

  localparam int FLG_C = 3;
  localparam int FLG_N = 2;
  localparam int FLG_O = 1;
  localparam int FLG_Z = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;

endpackage

// File: rtl/alu_regfile.sv
// Register file: three combinational read ports (a, b, c),
// two write ports (port w0 wins on same address), async clear on rst.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] ra_addr,
  output logic [DATA_W-1:0]        ra_data,
  input  logic [$clog2(NREGS)-1:0] rb_addr,
  output logic [DATA_W-1:0]        rb_data,
  input  logic [$clog2(NREGS)-1:0] rc_addr,
  output logic [DATA_W-1:0]        rc_data,
  input  logic                     w0_en,
  input  logic [$clog2(NREGS)-1:0] w0_addr,
  input  logic [DATA_W-1:0]        w0_data,
  input  logic                     w1_en,
  input  logic [$clog2(NREGS)-1:0] w1_addr,
  input  logic [DATA_W-1:0]        w1_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];
  assign rc_data = regs_q[rc_addr];

  // w0 applied last so it overrides w1 on a shared address
  always_comb begin
    regs_d = regs_q;
    if (w1_en) regs_d[w1_addr] = w1_data;
    if (w0_en) regs_d[w0_addr] = w0_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// ALU sequencer: accepts one command, drives the shared ALU, writes back.
// Optional macro ALU_CTRL_FLAGS_HOLD_EN: only add/sub update flags.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [$clog2(NREGS)-1:0] cmd_dst,
  input  logic [$clog2(NREGS)-1:0] cmd_src_a,
  input  logic [$clog2(NREGS)-1:0] cmd_src_b,
  output logic                     done,
  output logic [3:0]               flags,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [2:0]               alu_op,
  output logic                     alu_enable_out,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic [3:0]               alu_flags
);

  localparam int AW = $clog2(NREGS);

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [AW-1:0]     dst_q, dst_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              done_q, done_d;
  logic [3:0]        flags_q, flags_d;
  logic              wb_en;
  logic              flags_upd;
  logic [DATA_W-1:0] src_a_data;
  logic [DATA_W-1:0] src_b_data;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (cmd_src_a),
    .ra_data (src_a_data),
    .rb_addr (cmd_src_b),
    .rb_data (src_b_data),
    .rc_addr (rd_addr),
    .rc_data (rd_data),
    .w0_en   (wb_en),
    .w0_addr (dst_q),
    .w0_data (alu_out),
    .w1_en   (wr_en),
    .w1_addr (wr_addr),
    .w1_data (wr_data)
  );

`ifdef ALU_CTRL_FLAGS_HOLD_EN
  assign flags_upd = (op_q == OP_ADD) || (op_q == OP_SUB);
`else
  assign flags_upd = 1'b1;
`endif

  assign cmd_ready      = (state_q == ST_IDLE);
  assign alu_enable_out = (state_q == ST_EXEC) ||
                          (state_q == ST_WB);
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = op_q;
  assign done = done_q;
  assign flags = flags_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    flags_d = flags_q;
    wb_en   = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (cmd_valid) begin
          state_d = ST_SETUP;
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          a_d     = src_a_data;
          b_d     = src_b_data;
        end
      end
      (state_q == ST_SETUP): state_d = ST_EXEC;
      (state_q == ST_EXEC):  state_d = ST_WB;
      // alu_out holds the value captured at the end of EXEC
      (state_q == ST_WB): begin
        state_d = ST_IDLE;
        wb_en   = 1'b1;
        done_d  = 1'b1;
        if (flags_upd) flags_d = alu_flags;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: ALU device model, cycle-level reference model,
// directed commands with hand-computed literal expectations.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_dst;
  logic [2:0] cmd_src_a;
  logic [2:0] cmd_src_b;
  logic       done;
  logic [3:0] flags;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic       alu_enable_out;
  logic [7:0] alu_out = 8'h00;
  logic [3:0] alu_flags = 4'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_ctrl #(.DATA_W(8), .NREGS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_dst        (cmd_dst),
    .cmd_src_a      (cmd_src_a),
    .cmd_src_b      (cmd_src_b),
    .done           (done),
    .flags          (flags),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_op         (alu_op),
    .alu_enable_out (alu_enable_out),
    .alu_out        (alu_out),
    .alu_flags      (alu_flags)
  );

  // Returns {C,N,O,Z, result}
  function automatic logic [11:0] alu_fn(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    logic [7:0] r;
    logic c;
    logic o;
    c = 1'b0;
    o = 1'b0;
    r = 8'h00;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        o = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        r = a - b;
        c = (a < b);
        o = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd2: r = a | b;
      3'd3: r = a & b;
      3'd4: r = ~a;
      3'd5: r = (a == b) ? 8'h01 : 8'h00;
      3'd6: begin r = a >> 1; c = a[0]; end
      default: begin r = a << 1; c = a[7]; end
    endcase
    return {c, r[7], o, (r == 8'h00), r};
  endfunction

  // External ALU device: registered capture while enabled
  always @(posedge clk) begin
    if (alu_enable_out)
      {alu_flags, alu_out} <= alu_fn(alu_op, alu_a, alu_b);
  end

  // Reference model: m_age counts cycles since the accept edge
  logic [7:0] m_r [8];
  logic [3:0] m_flags;
  logic [7:0] m_a, m_b;
  logic [2:0] m_op, m_dst;
  logic       m_done;
  int         m_age;

  function automatic bit flag_upd(input logic [2:0] op);
`ifdef ALU_CTRL_FLAGS_HOLD_EN
    return (op == 3'd0) || (op == 3'd1);
`else
    return 1'b1;
`endif
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_flags = 4'h0;
    m_a = 8'h00;
    m_b = 8'h00;
    m_op = 3'd0;
    m_dst = 3'd0;
    m_done = 1'b0;
    m_age = 0;
  endtask

  task automatic m_edge();
    logic [11:0] res;
    bit wb;
    wb = 1'b0;
    res = '0;
    if (rst) begin
      m_reset();
      return;
    end
    m_done = 1'b0;
    if (m_age == 0 && cmd_valid) begin
      m_a = m_r[cmd_src_a];
      m_b = m_r[cmd_src_b];
      m_op = cmd_op;
      m_dst = cmd_dst;
      m_age = 1;
    end else if (m_age == 3) begin
      res = alu_fn(m_op, m_a, m_b);
      wb = 1'b1;
      m_done = 1'b1;
      if (flag_upd(m_op)) m_flags = res[11:8];
      m_age = 0;
    end else if (m_age > 0) begin
      m_age++;
    end
    if (wr_en) m_r[wr_addr] = wr_data;
    if (wb) m_r[m_dst] = res[7:0];
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compare();
    chk("cmd_ready", cmd_ready, (m_age == 0));
    chk("done", done, m_done);
    chk("flags", flags, m_flags);
    chk("alu_enable_out", alu_enable_out, (m_age >= 2));
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_op", alu_op, m_op);
    chk("rd_data", rd_data, m_r[rd_addr]);
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic ext_write(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic peek(input logic [2:0] a, input logic [7:0] exp,
                      input string name);
    rd_addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [2:0] dst,
                         input logic [2:0] sa, input logic [2:0] sb,
                         input bit cw, input logic [2:0] wa,
                         input logic [7:0] wd);
    int n, rl, en;
    cmd_op = op;
    cmd_dst = dst;
    cmd_src_a = sa;
    cmd_src_b = sb;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rl = cmd_ready ? 0 : 1;
    en = alu_enable_out ? 1 : 0;
    n = 0;
    while (!done && n < 8) begin
      if (n == 2 && cw) begin
        wr_en = 1'b1;
        wr_addr = wa;
        wr_data = wd;
      end
      tick();
      wr_en = 1'b0;
      n++;
      if (!cmd_ready) rl++;
      if (alu_enable_out) en++;
    end
    chk("latency", n, 3);
    chk("ready_low_cycles", rl, 3);
    chk("enable_cycles", en, 2);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_dst = 3'd0;
    cmd_src_a = 3'd0;
    cmd_src_b = 3'd0;
    wr_en = 1'b0;
    wr_addr = 3'd0;
    wr_data = 8'h00;
    rd_addr = 3'd0;
    m_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_flags", flags, 4'h0);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_enable", alu_enable_out, 0);

    // add with overflow
    ext_write(3'd1, 8'h40);
    ext_write(3'd2, 8'h41);
    run_cmd(3'd0, 3'd3, 3'd1, 3'd2, 0, 3'd0, 8'h00);
    peek(3'd3, 8'h81, "add_result");
    chk("add_flags", flags, 4'b0110);

    // or after add: flags hold or update
    ext_write(3'd1, 8'h03);
    ext_write(3'd2, 8'h11);
    run_cmd(3'd2, 3'd6, 3'd1, 3'd2, 0, 3'd0, 8'h00);
    peek(3'd6, 8'h13, "or_result");
`ifdef ALU_CTRL_FLAGS_HOLD_EN
    chk("or_flags", flags, 4'b0110);
`else
    chk("or_flags", flags, 4'b0000);
`endif

    // sub negative, then sub to zero
    ext_write(3'd1, 8'h01);
    ext_write(3'd2, 8'h02);
    run_cmd(3'd1, 3'd4, 3'd1, 3'd2, 0, 3'd0, 8'h00);
    peek(3'd4, 8'hFF, "sub_neg");
    chk("sub_neg_flags", flags, 4'b1100);
    ext_write(3'd1, 8'h81);
    ext_write(3'd2, 8'h81);
    run_cmd(3'd1, 3'd4, 3'd1, 3'd2, 0, 3'd0, 8'h00);
    peek(3'd4, 8'h00, "sub_zero");
    chk("sub_zero_flags", flags, 4'b0001);

    // comp and unary ops
    ext_write(3'd1, 8'h53);
    ext_write(3'd2, 8'h53);
    run_cmd(3'd5, 3'd5, 3'd1, 3'd2, 0, 3'd0, 8'h00);
    peek(3'd5, 8'h01, "comp_eq");
    run_cmd(3'd6, 3'd5, 3'd1, 3'd2, 0, 3'd0, 8'h00);
    peek(3'd5, 8'h29, "shr");
    run_cmd(3'd7, 3'd5, 3'd1, 3'd2, 0, 3'd0, 8'h00);
    peek(3'd5, 8'hA6, "shl");
    run_cmd(3'd4, 3'd5, 3'd1, 3'd2, 0, 3'd0, 8'h00);
    peek(3'd5, 8'hAC, "not");

    // write collisions
    ext_write(3'd1, 8'h40);
    ext_write(3'd2, 8'h41);
    ext_write(3'd3, 8'h00);
    run_cmd(3'd0, 3'd3, 3'd1, 3'd2, 1, 3'd3, 8'h55);
    peek(3'd3, 8'h81, "collide_same");
    ext_write(3'd3, 8'h00);
    run_cmd(3'd0, 3'd3, 3'd1, 3'd2, 1, 3'd5, 8'h55);
    peek(3'd3, 8'h81, "collide_diff_r3");
    peek(3'd5, 8'h55, "collide_diff_r5");

    // held-off commands: R7 += R1 three times over 12 edges
    ext_write(3'd1, 8'h01);
    ext_write(3'd7, 8'h00);
    cmd_op = 3'd0;
    cmd_dst = 3'd7;
    cmd_src_a = 3'd7;
    cmd_src_b = 3'd1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    cmd_valid = 1'b0;
    tick();
    peek(3'd7, 8'h03, "holdoff_acc");

    // reset during EXEC
    ext_write(3'd1, 8'h40);
    ext_write(3'd2, 8'h41);
    cmd_op = 3'd0;
    cmd_dst = 3'd3;
    cmd_src_a = 3'd1;
    cmd_src_b = 3'd2;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("exec_enable", alu_enable_out, 1);
    rst = 1'b1;
    #1;
    m_reset();
    compare();
    chk("rst_mid_flags", flags, 4'h0);
    chk("rst_mid_enable", alu_enable_out, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_done", done, 0);
    end
    chk("rst_rel_ready", cmd_ready, 1);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] a;
      a = i[2:0];
      peek(a, 8'h00, "rst_reg_clear");
    end
    ext_write(3'd1, 8'h40);
    ext_write(3'd2, 8'h41);
    run_cmd(3'd0, 3'd3, 3'd1, 3'd2, 0, 3'd0, 8'h00);
    peek(3'd3, 8'h81, "post_rst_add");
    chk("post_rst_flags", flags, 4'b0110);

    // a few random commands checked by the model
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      ext_write(3'd1, ra);
      ext_write(3'd2, rb);
      run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(3, 7)),
              3'd1, 3'd2, 0, 3'd0, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
